// File: rtl/cmd_pkg.sv
// Shared constants for the command decoder: frame layout, opcodes,
// read-handshake state encoding.
package cmd_pkg;

    localparam int FRAME_LEN = 57;
    localparam int SHORT_LEN = 8;
    localparam int CNT_W     = 6;

    localparam int HDR_LSB = 5;
    localparam int HDR_W   = 3;
    localparam logic [HDR_W-1:0] SHORT_HDR = 3'b010;

    localparam int TYPE_LSB = 54;
    localparam int TYPE_W   = 3;
    localparam int ID_LSB   = 49;
    localparam int ID_W     = 5;
    localparam int ADDR_LSB = 41;
    localparam int ADDR_FW  = 8;
    localparam int DATA_LSB = 9;
    localparam int DATA_FW  = 32;

    localparam logic [TYPE_W-1:0] TYPE_WR = 3'b110;
    localparam logic [TYPE_W-1:0] TYPE_RD = 3'b111;

    localparam int OP_W = 5;
    localparam logic [OP_W-1:0] OP_SOFTRST = 5'b00001;
    localparam logic [OP_W-1:0] OP_BCRST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_CAL     = 5'b00100;
    localparam logic [OP_W-1:0] OP_CLR     = 5'b00011;

    localparam int ERR_W = 8;

    localparam int P_WR   = 0;
    localparam int P_SOFT = 1;
    localparam int P_BC   = 2;
    localparam int P_CAL  = 3;
    localparam int NPULSE = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } rdState_e;

endpackage

// File: rtl/tmr_vote.sv
// Bitwise two-of-three majority voter for triplicated registers.
module tmr_vote #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/cmd_decoder.sv
// Frame-completion detector and decoder for the serial command path.
// Every flop is triplicated; next state is built from voted values.
module cmd_decoder
    import cmd_pkg::*;
#(
    parameter int CHIPID_W = 5,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter logic [CHIPID_W-1:0] BCAST_ID = 5'h1F
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [56:0]          cmd_reg,
    input  logic                 cmd_pending,
    input  logic [CNT_W-1:0]     cmd_count,
    input  logic [CHIPID_W-1:0]  chip_id,
    output logic                 reg_wr_en,
    output logic [ADDR_W-1:0]    reg_addr,
    output logic [DATA_W-1:0]    reg_wdata,
    output logic                 reg_rd_req,
    input  logic                 reg_rd_ack,
    output logic                 soft_rst,
    output logic                 bc_rst,
    output logic                 cal_pulse,
    output logic                 rd_overflow,
    output logic [ERR_W-1:0]     err_count
);

    rdState_e stateQ0, stateQ1, stateQ2;
    rdState_e stateV, stateN;
    logic     stateVBit;

    logic [ADDR_W-1:0] rdAddrQ [3];
    logic [ADDR_W-1:0] regAddrQ [3];
    logic [DATA_W-1:0] wdataQ [3];
    logic [NPULSE-1:0] pulseQ [3];
    logic              ovfQ [3];
    logic [ERR_W-1:0]  errQ [3];

    logic [ADDR_W-1:0] rdAddrV, rdAddrN;
    logic [ADDR_W-1:0] regAddrV, regAddrN;
    logic [DATA_W-1:0] wdataV, wdataN;
    logic [NPULSE-1:0] pulseV, pulseN;
    logic              ovfV, ovfN;
    logic [ERR_W-1:0]  errV, errN;

    logic longDone, shortDone, idHit;
    logic isWr, isRd, badLong, rdTake, errInc;
    logic [TYPE_W-1:0]   frmType;
    logic [CHIPID_W-1:0] frmId;
    logic [ADDR_W-1:0]   frmAddr;
    logic [DATA_W-1:0]   frmData;
    logic [OP_W-1:0]     opcode;
    logic                unusedBits;

    assign longDone  = cmd_pending && (cmd_count == CNT_W'(FRAME_LEN));
    assign shortDone = cmd_pending
                    && (cmd_count == CNT_W'(SHORT_LEN))
                    && (cmd_reg[HDR_LSB +: HDR_W] == SHORT_HDR);

    assign frmType = cmd_reg[TYPE_LSB +: TYPE_W];
    assign frmId   = CHIPID_W'(cmd_reg[ID_LSB +: ID_W]);
    assign frmAddr = ADDR_W'(cmd_reg[ADDR_LSB +: ADDR_FW]);
    assign frmData = DATA_W'(cmd_reg[DATA_LSB +: DATA_FW]);
    assign opcode  = cmd_reg[OP_W-1:0];
    assign unusedBits = cmd_reg[8];

    assign idHit   = (frmId == chip_id) || (frmId == BCAST_ID);
    assign isWr    = longDone && idHit && (frmType == TYPE_WR);
    assign isRd    = longDone && idHit && (frmType == TYPE_RD);
    assign badLong = longDone && idHit && !isWr && !isRd;

    tmr_vote #(.WIDTH(1)) uVoteState (
        .a(logic'(stateQ0)), .b(logic'(stateQ1)),
        .c(logic'(stateQ2)), .y(stateVBit)
    );
    assign stateV = rdState_e'(stateVBit);

    tmr_vote #(.WIDTH(ADDR_W)) uVoteRdAddr (
        .a(rdAddrQ[0]), .b(rdAddrQ[1]), .c(rdAddrQ[2]), .y(rdAddrV)
    );
    tmr_vote #(.WIDTH(ADDR_W)) uVoteRegAddr (
        .a(regAddrQ[0]), .b(regAddrQ[1]), .c(regAddrQ[2]), .y(regAddrV)
    );
    tmr_vote #(.WIDTH(DATA_W)) uVoteWdata (
        .a(wdataQ[0]), .b(wdataQ[1]), .c(wdataQ[2]), .y(wdataV)
    );
    tmr_vote #(.WIDTH(NPULSE)) uVotePulse (
        .a(pulseQ[0]), .b(pulseQ[1]), .c(pulseQ[2]), .y(pulseV)
    );
    tmr_vote #(.WIDTH(1)) uVoteOvf (
        .a(ovfQ[0]), .b(ovfQ[1]), .c(ovfQ[2]), .y(ovfV)
    );
    tmr_vote #(.WIDTH(ERR_W)) uVoteErr (
        .a(errQ[0]), .b(errQ[1]), .c(errQ[2]), .y(errV)
    );

    always_comb begin
        stateN   = stateV;
        rdAddrN  = rdAddrV;
        regAddrN = regAddrV;
        wdataN   = wdataV;
        pulseN   = '0;
        ovfN     = ovfV;
        errN     = errV;
        errInc   = badLong;
        rdTake   = isRd && ((stateV == ST_IDLE) || reg_rd_ack);

        if ((stateV == ST_REQ) && reg_rd_ack) begin
            stateN = ST_IDLE;
        end

        // An ack in the same cycle frees the slot for the new read.
        if (rdTake) begin
            stateN  = ST_REQ;
            rdAddrN = frmAddr;
        end else if (isRd) begin
            ovfN = 1'b1;
        end

        if (isWr) begin
            regAddrN     = frmAddr;
            wdataN       = frmData;
            pulseN[P_WR] = 1'b1;
        end else if (stateN == ST_REQ) begin
            regAddrN = rdAddrN;
        end

        if (shortDone) begin
            unique case (opcode)
                OP_SOFTRST: pulseN[P_SOFT] = 1'b1;
                OP_BCRST:   pulseN[P_BC]   = 1'b1;
                OP_CAL:     pulseN[P_CAL]  = 1'b1;
                OP_CLR: begin
                    ovfN = 1'b0;
                    errN = '0;
                end
                default:    errInc = 1'b1;
            endcase
        end

        if (errInc && (errV != '1)) begin
            errN = errV + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stateQ0 <= ST_IDLE;
            stateQ1 <= ST_IDLE;
            stateQ2 <= ST_IDLE;
            for (int i = 0; i < 3; i++) begin
                rdAddrQ[i]  <= '0;
                regAddrQ[i] <= '0;
                wdataQ[i]   <= '0;
                pulseQ[i]   <= '0;
                ovfQ[i]     <= 1'b0;
                errQ[i]     <= '0;
            end
        end else begin
            stateQ0 <= stateN;
            stateQ1 <= stateN;
            stateQ2 <= stateN;
            for (int i = 0; i < 3; i++) begin
                rdAddrQ[i]  <= rdAddrN;
                regAddrQ[i] <= regAddrN;
                wdataQ[i]   <= wdataN;
                pulseQ[i]   <= pulseN;
                ovfQ[i]     <= ovfN;
                errQ[i]     <= errN;
            end
        end
    end

    assign reg_wr_en   = pulseV[P_WR];
    assign soft_rst    = pulseV[P_SOFT];
    assign bc_rst      = pulseV[P_BC];
    assign cal_pulse   = pulseV[P_CAL];
    assign reg_addr    = regAddrV;
    assign reg_wdata   = wdataV;
    assign reg_rd_req  = (stateV == ST_REQ);
    assign rd_overflow = ovfV;
    assign err_count   = errV;

endmodule

// File: tb/tb_cmd_decoder.sv
// Randomised self-checking bench for cmd_decoder against a
// frame-level reference model.
module tb_cmd_decoder;
    import cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rstb;
    logic [56:0] cmd_reg;
    logic        cmd_pending;
    logic [5:0]  cmd_count;
    logic [4:0]  chip_id;
    logic        reg_wr_en;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_rd_req;
    logic        reg_rd_ack;
    logic        soft_rst;
    logic        bc_rst;
    logic        cal_pulse;
    logic        rd_overflow;
    logic [7:0]  err_count;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state
    logic        mReq;
    logic [7:0]  mRdAddr;
    logic [7:0]  mAddr;
    logic [31:0] mWdata;
    logic        mOvf;
    int          mErr;
    logic        eWr, eSoft, eBc, eCal;

    cmd_decoder dut (
        .clk(clk),
        .rstb(rstb),
        .cmd_reg(cmd_reg),
        .cmd_pending(cmd_pending),
        .cmd_count(cmd_count),
        .chip_id(chip_id),
        .reg_wr_en(reg_wr_en),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rd_req(reg_rd_req),
        .reg_rd_ack(reg_rd_ack),
        .soft_rst(soft_rst),
        .bc_rst(bc_rst),
        .cal_pulse(cal_pulse),
        .rd_overflow(rd_overflow),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mReq = 1'b0; mRdAddr = '0; mAddr = '0; mWdata = '0;
        mOvf = 1'b0; mErr = 0;
        eWr = 1'b0; eSoft = 1'b0; eBc = 1'b0; eCal = 1'b0;
    endfunction

    // One clock of frame semantics: what the outputs must show after the edge.
    function automatic void modelStep(input logic [56:0] r, input logic p,
                                      input logic [5:0] c, input logic a);
        logic [2:0] ty;
        logic [4:0] id;
        bit         isLong, isShort;
        eWr = 1'b0; eSoft = 1'b0; eBc = 1'b0; eCal = 1'b0;
        isLong  = p && (c == 6'd57);
        isShort = p && (c == 6'd8) && (r[7:5] == 3'b010);
        ty = r[56:54];
        id = r[53:49];
        if (a && mReq) mReq = 1'b0;
        if (isShort) begin
            case (r[4:0])
                5'd1: eSoft = 1'b1;
                5'd2: eBc = 1'b1;
                5'd4: eCal = 1'b1;
                5'd3: begin mOvf = 1'b0; mErr = 0; end
                default: mErr = (mErr >= 255) ? 255 : mErr + 1;
            endcase
        end
        if (isLong && (id == chip_id || id == 5'h1F)) begin
            if (ty == 3'b110) begin
                eWr = 1'b1;
                mAddr = r[48:41];
                mWdata = r[40:9];
            end else if (ty == 3'b111) begin
                if (!mReq) begin
                    mReq = 1'b1;
                    mRdAddr = r[48:41];
                end else begin
                    mOvf = 1'b1;
                end
            end else begin
                mErr = (mErr >= 255) ? 255 : mErr + 1;
            end
        end
        // A pending read owns the address bus except on a write strobe cycle.
        if (!eWr && mReq) mAddr = mRdAddr;
    endfunction

    task automatic compareAll();
        checkVal("wr_en", 64'(reg_wr_en), 64'(eWr));
        checkVal("soft_rst", 64'(soft_rst), 64'(eSoft));
        checkVal("bc_rst", 64'(bc_rst), 64'(eBc));
        checkVal("cal_pulse", 64'(cal_pulse), 64'(eCal));
        checkVal("rd_req", 64'(reg_rd_req), 64'(mReq));
        checkVal("reg_addr", 64'(reg_addr), 64'(mAddr));
        checkVal("reg_wdata", 64'(reg_wdata), 64'(mWdata));
        checkVal("rd_overflow", 64'(rd_overflow), 64'(mOvf));
        checkVal("err_count", 64'(err_count), 64'(mErr));
    endtask

    task automatic tick(input logic [56:0] r, input logic p,
                        input logic [5:0] c, input logic a);
        cmd_reg = r; cmd_pending = p; cmd_count = c; reg_rd_ack = a;
        modelStep(r, p, c, a);
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    function automatic logic [56:0] longFrm(input logic [2:0] t,
        input logic [4:0] id, input logic [7:0] ad, input logic [31:0] d);
        return {t, id, ad, d, 9'($urandom)};
    endfunction

    function automatic logic [56:0] shortFrm(input logic [4:0] op);
        return {49'({$urandom, $urandom}), 3'b010, op};
    endfunction

    task automatic idle(input logic a);
        tick(57'({$urandom, $urandom}), 1'b0, 6'd0, a);
    endtask

    task automatic randomCycle();
        logic [56:0] r;
        logic [5:0]  c;
        logic [4:0]  op;
        logic [4:0]  id;
        logic [2:0]  ty;
        logic        p, a;
        int          k;
        r = 57'({$urandom, $urandom});
        a = ($urandom_range(0, 3) == 0);
        k = $urandom_range(0, 9);
        case (k)
            0: begin p = 1'b0; c = 6'($urandom_range(0, 63)); end
            1: begin p = 1'b1; c = 6'($urandom_range(58, 63)); end
            2: begin
                p = 1'b1;
                c = 6'($urandom_range(0, 56));
                if (c == 6'd8) r[7:5] = 3'b110;
            end
            3, 4: begin
                p = 1'b1; c = 6'd8;
                case ($urandom_range(0, 5))
                    0: op = 5'b00001;
                    1: op = 5'b00010;
                    2: op = 5'b00100;
                    3: op = 5'b00011;
                    default: op = 5'($urandom);
                endcase
                r = shortFrm(op);
            end
            default: begin
                p = 1'b1; c = 6'd57;
                case ($urandom_range(0, 4))
                    0, 1: ty = 3'b110;
                    2, 3: ty = 3'b111;
                    default: ty = 3'($urandom);
                endcase
                case ($urandom_range(0, 2))
                    0: id = chip_id;
                    1: id = 5'h1F;
                    default: id = 5'($urandom);
                endcase
                r = longFrm(ty, id, 8'($urandom), $urandom);
            end
        endcase
        tick(r, p, c, a);
    endtask

    initial begin
        rstb = 1'b0;
        cmd_reg = '0; cmd_pending = 1'b0; cmd_count = '0;
        reg_rd_ack = 1'b0; chip_id = 5'h03;
        modelReset();
        repeat (2) @(negedge clk);
        compareAll();
        checkVal("reset_state", 64'(dut.stateV), 64'(ST_IDLE));
        rstb = 1'b1;
        idle(1'b0);

        // Directed write
        tick(longFrm(3'b110, 5'h03, 8'h1A, 32'hDEADBEEF), 1'b1, 6'd57, 1'b0);
        checkVal("wr_strobe", 64'(reg_wr_en), 64'h1);
        checkVal("wr_addr", 64'(reg_addr), 64'h1A);
        checkVal("wr_data", 64'(reg_wdata), 64'hDEADBEEF);
        idle(1'b0);
        checkVal("wr_strobe_one", 64'(reg_wr_en), 64'h0);

        // Broadcast read with ack four cycles later
        tick(longFrm(3'b111, 5'h1F, 8'h05, $urandom), 1'b1, 6'd57, 1'b0);
        checkVal("rd_req_set", 64'(reg_rd_req), 64'h1);
        repeat (3) idle(1'b0);
        checkVal("rd_req_held", 64'(reg_rd_req), 64'h1);
        idle(1'b1);
        checkVal("rd_req_clr", 64'(reg_rd_req), 64'h0);
        checkVal("rd_no_ovf", 64'(rd_overflow), 64'h0);

        // Overflow on a second read without ack, then clear
        tick(longFrm(3'b111, 5'h03, 8'h05, $urandom), 1'b1, 6'd57, 1'b0);
        tick(longFrm(3'b111, 5'h03, 8'h06, $urandom), 1'b1, 6'd57, 1'b0);
        checkVal("ovf_set", 64'(rd_overflow), 64'h1);
        checkVal("ovf_addr", 64'(reg_addr), 64'h05);
        tick(shortFrm(5'b00011), 1'b1, 6'd8, 1'b0);
        checkVal("ovf_clr", 64'(rd_overflow), 64'h0);
        checkVal("err_clr", 64'(err_count), 64'h0);
        idle(1'b1);

        // Fast commands back to back, then an unknown payload
        tick(shortFrm(5'b00001), 1'b1, 6'd8, 1'b0);
        checkVal("soft_rst", 64'(soft_rst), 64'h1);
        tick(shortFrm(5'b00010), 1'b1, 6'd8, 1'b0);
        checkVal("bc_rst", 64'(bc_rst), 64'h1);
        tick(shortFrm(5'b00100), 1'b1, 6'd8, 1'b0);
        checkVal("cal_pulse", 64'(cal_pulse), 64'h1);
        tick(shortFrm(5'b01111), 1'b1, 6'd8, 1'b0);
        checkVal("err_one", 64'(err_count), 64'h1);
        checkVal("cal_one", 64'(cal_pulse), 64'h0);

        // Foreign chip ID is ignored
        tick(longFrm(3'b110, 5'h07, 8'h33, $urandom), 1'b1, 6'd57, 1'b0);
        checkVal("foreign_wr", 64'(reg_wr_en), 64'h0);
        checkVal("foreign_err", 64'(err_count), 64'h1);

        for (int i = 0; i < 3000; i++) randomCycle();

        // Error counter saturation
        tick(shortFrm(5'b00011), 1'b1, 6'd8, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick(longFrm(3'b000, 5'h03, 8'($urandom), $urandom),
                 1'b1, 6'd57, 1'b0);
        end
        checkVal("err_sat", 64'(err_count), 64'd255);

        // Single-replica upset on the read FSM
        idle(1'b1);
        tick(longFrm(3'b111, 5'h03, 8'h44, $urandom), 1'b1, 6'd57, 1'b0);
        force dut.stateQ1 = ST_IDLE;
        #1;
        checkVal("seu_req", 64'(reg_rd_req), 64'h1);
        checkVal("seu_addr", 64'(reg_addr), 64'h44);
        release dut.stateQ1;
        idle(1'b0);
        checkVal("seu_fixed", 64'(dut.stateQ1), 64'(ST_REQ));

        // Asynchronous reset in the middle of a handshake
        #2;
        rstb = 1'b0;
        #1;
        modelReset();
        checkVal("arst_req", 64'(reg_rd_req), 64'h0);
        checkVal("arst_state", 64'(dut.stateV), 64'(ST_IDLE));
        checkVal("arst_err", 64'(err_count), 64'h0);
        @(negedge clk);
        rstb = 1'b1;
        repeat (3) idle(1'b0);
        checkVal("no_replay", 64'(reg_rd_req), 64'h0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
